multisim_poll_scheduler: RTL



---
 rtl/multisim_poll_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multisim_poll_scheduler.sv
// Round-robin scheduler that shares a single poll slot among NUM_CHANNELS clients,
// with a per-channel adaptive backoff that grows on empty polls and resets on hits.
module multisim_poll_scheduler #(
  parameter int NUM_CHANNELS       = 4,
  parameter int DELAY_WIDTH        = 16,
  parameter int DELAY_ACTIVE       = 0,
  parameter int DELAY_INACTIVE_MIN = 1,
  parameter int DELAY_INACTIVE_MAX = 1000,
  parameter int IDX_W              = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] chan_req,
  output logic                    poll_vld,
  output logic [IDX_W-1:0]        poll_idx,
  input  logic                    poll_rdy,
  input  logic                    resp_vld,
  input  logic                    resp_hit,
  output logic [NUM_CHANNELS-1:0] chan_grant,
  output logic                    busy,
  output logic                    resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_poll_idx;
  logic             r_poll_vld;
  logic             r_resp_err;

  logic [NUM_CHANNELS-1:0]                  w_elig;
  logic [NUM_CHANNELS-1:0][DELAY_WIDTH-1:0] w_last;
  logic                                     w_any_elig;
  logic [IDX_W-1:0]                         w_sel;
  logic                                     w_resp_done;
  logic [DELAY_WIDTH:0]                     w_dbl;
  logic [DELAY_WIDTH-1:0]                   w_prev;
  logic [DELAY_WIDTH-1:0]                   w_new_delay;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
    return IDX_W'(s);
  endfunction

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    w_sel      = r_rr_ptr;
    w_any_elig = 1'b0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (w_elig[wrap_add(r_rr_ptr, k)]) begin
        w_sel      = wrap_add(r_rr_ptr, k);
        w_any_elig = 1'b1;
      end
    end
  end

  assign w_resp_done = (r_state == S_WAIT) && resp_vld;

  // Doubling at one extra bit so a large prev clamps instead of wrapping.
  assign w_prev = w_last[r_poll_idx];
  assign w_dbl  = {w_prev, 1'b0};

  always_comb begin
    w_new_delay = w_dbl[DELAY_WIDTH-1:0];
    if (resp_hit) begin
      w_new_delay = DELAY_WIDTH'(DELAY_ACTIVE);
    end else if (w_prev == '0) begin
      w_new_delay = DELAY_WIDTH'(DELAY_INACTIVE_MIN);
    end else if (w_dbl > (DELAY_WIDTH+1)'(DELAY_INACTIVE_MAX)) begin
      w_new_delay = DELAY_WIDTH'(DELAY_INACTIVE_MAX);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_elig) w_state_next = S_ISSUE;
      S_ISSUE: if (poll_rdy)   w_state_next = S_WAIT;
      S_WAIT:  if (resp_vld)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_poll_vld <= 1'b0;
      r_poll_idx <= '0;
      r_rr_ptr   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && w_any_elig) begin
        r_poll_vld <= 1'b1;
        r_poll_idx <= w_sel;
      end else if ((r_state == S_ISSUE) && poll_rdy) begin
        r_poll_vld <= 1'b0;
      end
      if (w_resp_done) r_rr_ptr <= wrap_add(r_poll_idx, 1);
      if (resp_vld && (r_state != S_WAIT)) r_resp_err <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic [DELAY_WIDTH-1:0] r_cnt;
    logic [DELAY_WIDTH-1:0] r_last;
    logic                   w_mine;
    logic                   w_load;

    assign w_mine = (r_poll_idx == IDX_W'(gi));
    assign w_load = w_resp_done && w_mine;

    // The channel owning the outstanding poll keeps its counter frozen.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_last <= '0;
      end else if (w_load) begin
        r_cnt  <= w_new_delay;
        r_last <= w_new_delay;
      end else if (!((r_state != S_IDLE) && w_mine) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_elig[gi]     = chan_req[gi] && (r_cnt == '0);
    assign w_last[gi]     = r_last;
    assign chan_grant[gi] = w_load;
  end

  assign poll_vld = r_poll_vld;
  assign poll_idx = r_poll_idx;
  assign busy     = (r_state != S_IDLE);
  assign resp_err = r_resp_err;

endmodule
